// File: rtl/core_pkg.sv
// Shared definitions for the core's bus monitors: boot overlay states and
// the 68030 function code that marks CPU-space (IACK/coprocessor) cycles.
package core_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    LAST = 2'd1,
    DONE = 2'd2
  } boot_state_e;

  localparam logic [2:0] FC_CPU_SPACE = 3'b111;

endpackage

// File: rtl/boot_vector_overlay_if.sv
// Bus-side bundle of the boot vector overlay: CPU strobe and function code,
// control pulses from the register file, and the status returned to the decoder.
interface boot_vector_overlay_if #(
  parameter int CW = 3
);

  logic          as;
  logic [2:0]    fc;
  logic          rearm;
  logic          force_done;
  logic          vector_fetched;
  logic          overlay_active;
  logic [CW-1:0] cycle_count;

  modport master (
    output as, fc, rearm, force_done,
    input  vector_fetched, overlay_active, cycle_count
  );

  modport slave (
    input  as, fc, rearm, force_done,
    output vector_fetched, overlay_active, cycle_count
  );

endinterface

// File: rtl/strobe_edge_sync.sv
// Optional synchroniser for an active-low bus strobe and its side data,
// followed by a falling-edge detector that only fires after a genuine idle level.
module strobe_edge_sync #(
  parameter int SYNC_STAGES = 0,
  parameter int DW          = 3
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          i_strobe,
  input  logic [DW-1:0] i_data,
  output logic          o_strobe_s,
  output logic [DW-1:0] o_data_s,
  output logic          o_fall
);

  logic w_valid_s;
  logic r_last;
  logic r_armed;

  generate
    if (SYNC_STAGES == 0) begin : g_bypass
      assign o_strobe_s = i_strobe;
      assign o_data_s   = i_data;
      assign w_valid_s  = 1'b1;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0]         r_strobe_pipe;
      logic [SYNC_STAGES-1:0]         r_valid_pipe;
      logic [SYNC_STAGES-1:0][DW-1:0] r_data_pipe;

      // The valid bits mark which stages hold real samples rather than reset values.
      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          r_strobe_pipe <= '1;
          r_valid_pipe  <= '0;
          r_data_pipe   <= '0;
        end else begin
          r_strobe_pipe[0] <= i_strobe;
          r_valid_pipe[0]  <= 1'b1;
          r_data_pipe[0]   <= i_data;
          for (int i = 1; i < SYNC_STAGES; i++) begin
            r_strobe_pipe[i] <= r_strobe_pipe[i-1];
            r_valid_pipe[i]  <= r_valid_pipe[i-1];
            r_data_pipe[i]   <= r_data_pipe[i-1];
          end
        end
      end

      assign o_strobe_s = r_strobe_pipe[SYNC_STAGES-1];
      assign o_data_s   = r_data_pipe[SYNC_STAGES-1];
      assign w_valid_s  = r_valid_pipe[SYNC_STAGES-1];
    end
  endgenerate

  // A strobe already low when reset releases is mid-cycle, so edges wait for a real high.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_last  <= 1'b1;
      r_armed <= 1'b0;
    end else begin
      r_last  <= o_strobe_s;
      r_armed <= r_armed | (o_strobe_s & w_valid_s);
    end
  end

  assign o_fall = r_armed && r_last && !o_strobe_s;

endmodule

// File: rtl/boot_vector_overlay.sv
// Counts qualified CPU bus cycles after reset and tells the address decoder
// when the reset-vector fetches are done so the boot ROM overlay can be dropped.
module boot_vector_overlay
  import core_pkg::*;
#(
  parameter int FETCH_COUNT    = 5,
  parameter int SYNC_STAGES    = 0,
  parameter int HOLD_TO_NEGATE = 1,
  parameter int QUALIFY_FC     = 1,
  parameter int CW             = $clog2(FETCH_COUNT + 1)
) (
  input  logic                  clock,
  input  logic                  reset,
  boot_vector_overlay_if.slave  bus
);

  localparam logic [CW-1:0] TARGET = CW'(FETCH_COUNT);

  logic          w_as_s;
  logic [2:0]    w_fc_s;
  logic          w_fall;
  logic          w_qual;
  logic          r_qedge;
  logic [CW-1:0] r_count;
  logic [CW-1:0] w_next_count;
  logic          r_fetched;
  boot_state_e   r_state;
  boot_state_e   w_next_state;

  strobe_edge_sync #(
    .SYNC_STAGES (SYNC_STAGES),
    .DW          (3)
  ) u_strobe_sync (
    .clock      (clock),
    .reset      (reset),
    .i_strobe   (bus.as),
    .i_data     (bus.fc),
    .o_strobe_s (w_as_s),
    .o_data_s   (w_fc_s),
    .o_fall     (w_fall)
  );

  assign w_qual = w_fall && !((QUALIFY_FC != 0) && (w_fc_s == FC_CPU_SPACE));

  // A control pulse also discards an edge sampled on the same clock.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_qedge   <= 1'b0;
      r_state   <= BOOT;
      r_count   <= '0;
      r_fetched <= 1'b0;
    end else begin
      r_qedge   <= w_qual && !bus.rearm && !bus.force_done;
      r_state   <= w_next_state;
      r_count   <= w_next_count;
      r_fetched <= (r_state == DONE) && !(bus.rearm && !bus.force_done);
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_next_count = r_count;
    if (bus.force_done) begin
      w_next_state = DONE;
    end else if (bus.rearm) begin
      w_next_state = BOOT;
      w_next_count = '0;
    end else begin
      unique case (r_state)
        BOOT: begin
          if (r_qedge) begin
            w_next_count = r_count + CW'(1);
            if (w_next_count == TARGET) begin
              w_next_state = (HOLD_TO_NEGATE != 0) ? LAST : DONE;
            end
          end
        end
        LAST: begin
          if (w_as_s) begin
            w_next_state = DONE;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.vector_fetched = r_fetched;
  assign bus.overlay_active = ~r_fetched;
  assign bus.cycle_count    = r_count;

endmodule

// File: doc/boot_vector_overlay.md
Name: boot_vector_overlay

Overview:
- Parametrised successor to the boot vector-fetch detector: counts qualified CPU bus cycles (AS assertions) after reset and tells the address decoder when the reset-vector fetches are complete, so the boot ROM overlay at address 0 can be dropped.
- Adds a configurable fetch count, an optional AS synchroniser, function-code qualification, deferred switch-over at AS negation, and software re-arm/force-done.
- Sits between the 68030 bus signals and the address decoder in the core.

Parameters:
- FETCH_COUNT, 5, qualified AS falling edges that complete the vector fetch; legal 1..255.
- SYNC_STAGES, 0, flops on `as` before edge detection; legal 0..3.
- HOLD_TO_NEGATE, 1, when 1 the switch-over waits for AS negation of the final counted cycle; when 0 it switches the clock after that edge.
- QUALIFY_FC, 1, when 1 cycles with fc == 3'b111 (CPU space/IACK) are not counted.
- CW, $clog2(FETCH_COUNT+1), counter width (derived; not overridden).

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- as  in  1  CPU address strobe, active-low.
- fc  in  3  CPU function code, sampled with `as` (same sync depth).
- rearm  in  1  single-cycle pulse from control register write; restores overlay.
- force_done  in  1  single-cycle pulse; ends overlay immediately.
- vector_fetched  out  1  1 = vector fetch complete, overlay off.
- overlay_active  out  1  exact complement of vector_fetched.
- cycle_count  out  CW  qualified cycles counted since last reset/rearm; saturates at FETCH_COUNT.

Behaviour:
- Reset (reset low, async): state=BOOT, cycle_count=0, sync flops and last_as = 1, vector_fetched=0, overlay_active=1. No glitch on release.
- as_s = `as` after SYNC_STAGES flops (wire-through if 0); fc_s delayed identically. Edge = as_s==0 && last_as==1; last_as <= as_s every clock.
- Qualified edge = edge && !(QUALIFY_FC && fc_s==3'b111).
- States (one-hot or encoded, designer's choice):
  - BOOT: a qualified edge increments cycle_count. If the new count == FETCH_COUNT: go to LAST if HOLD_TO_NEGATE, else DONE.
  - LAST: cycle_count held; on as_s==1, go to DONE.
  - DONE: vector_fetched=1 (registered output, asserted the cycle after state enters DONE at latest same-edge registered); counting stops, further edges ignored.
- Latency, SYNC_STAGES=0, HOLD_TO_NEGATE=0: vector_fetched rises on the 2nd clock edge after the clock edge sampling the FETCH_COUNT-th qualified falling AS (one edge-detect, one state register). Each sync stage adds one clock.
- rearm: from any state → BOOT, cycle_count=0 on the next clock. If as_s==0 when rearm arrives, the current cycle is not counted (last_as already 0); counting resumes on the next falling edge.
- force_done: from any state → DONE next clock; cycle_count unchanged.
- rearm and force_done in the same cycle: force_done wins.
- rearm or force_done coinciding with a qualified edge: the control pulse wins; the edge is discarded.
- Counter never wraps. Width rule: compare at exactly FETCH_COUNT in CW bits.
- overlay_active == ~vector_fetched at all times, including during reset.

Decomposition:
- Shared package core_pkg gets the state enum (BOOT, LAST, DONE) and the FC_CPU_SPACE = 3'b111 constant.
- One natural sub-module: strobe_edge_sync (SYNC_STAGES-deep synchroniser plus falling-edge detector, reset to 1), reusable by other bus monitors.

Test Plan:
- Defaults. Reset, then 5 AS cycles with fc=6 → cycle_count 1..5; vector_fetched rises only after AS negates in the 5th cycle; stays 1 through 10 further cycles; count stays 5.
- Qualification. QUALIFY_FC=1, cycles fc=6,7,6,6,6,6 → the fc=7 cycle is not counted; done after the 6th cycle. With QUALIFY_FC=0 → done after the 5th cycle.
- Immediate mode. HOLD_TO_NEGATE=0, SYNC_STAGES=2 → vector_fetched rises exactly 4 clocks after the 5th falling AS, while AS is still low.
- Re-arm. In DONE, pulse rearm while AS is low → overlay_active=1 and cycle_count=0 next clock; the in-flight cycle is not counted; 5 new cycles → done again.
- Force/priority. At count 2, assert rearm and force_done together → DONE with count 2. Separately, force_done in the same clock as a qualified edge → count unchanged.
- Async reset. Assert reset mid-cycle in LAST with AS low → outputs 0/1 immediately, count 0. Release with AS still low → that cycle is not counted.
